div_issue_ctrl: RTL

//  EX-stage requester for the multicycle divider (M-ext DIV/DIVU/REM/REMU). Accepts a decoded

---
 rtl/div_issue_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multicycle divider.
// Fast-paths divide-by-zero/overflow, otherwise runs the start/busy handshake.
module div_issue_ctrl #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [1:0]         op_ctrl,
    input  logic [D_WIDTH-1:0] op_a,
    input  logic [D_WIDTH-1:0] op_b,
    input  logic               flush,
    output logic               stall,
    output logic               res_valid,
    output logic [D_WIDTH-1:0] res_data,
    output logic               div_start,
    output logic [1:0]         div_ctrl,
    output logic [D_WIDTH-1:0] div_num,
    output logic [D_WIDTH-1:0] div_den,
    input  logic               div_busy,
    input  logic [D_WIDTH-1:0] div_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP,
        S_DRAIN,
        S_DSKIP
    } state_t;

    localparam logic [D_WIDTH-1:0] INT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    state_t             state;
    logic               accept;
    logic               b_zero;
    logic               ovf;
    logic [D_WIDTH-1:0] fast_res;

    assign accept = (state == S_IDLE) & op_valid & ~flush;
    assign b_zero = (op_b == '0);
    assign ovf    = ~op_ctrl[0] & (op_a == INT_MIN) & (op_b == '1);

    // op_ctrl[1] selects remainder
    always_comb begin
        fast_res = '0;
        unique case (1'b1)
            b_zero:  fast_res = op_ctrl[1] ? op_a : '1;
            ovf:     fast_res = op_ctrl[1] ? '0 : op_a;
            default: fast_res = '0;
        endcase
    end

    assign stall = accept
                 | (state inside {S_ISSUE, S_WAIT, S_CAPTURE})
                 | ((state inside {S_DRAIN, S_DSKIP}) & op_valid);

    assign res_valid = (state == S_RESP) & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            res_data  <= '0;
            div_start <= 1'b0;
            div_ctrl  <= '0;
            div_num   <= '0;
            div_den   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (b_zero | ovf) begin
                            res_data <= fast_res;
                            state    <= S_RESP;
                        end else begin
                            div_num   <= op_a;
                            div_den   <= op_b;
                            div_ctrl  <= op_ctrl;
                            div_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    div_start <= 1'b0;
                    state     <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush)
                        state <= S_DRAIN;
                    else if (!div_busy)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!flush)
                        res_data <= div_result;
                    state <= flush ? S_IDLE : S_RESP;
                end
                S_RESP: state <= S_IDLE;
                // divider cannot abort: wait out the run, then skip its result
                S_DRAIN: begin
                    if (!div_busy)
                        state <= S_DSKIP;
                end
                S_DSKIP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
